// File: rtl/psg_pkg.sv
// Shared definitions for the PSG output path: mixer FSM states and
// accumulator sizing helper.
package psg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StSat,
        StOut
    } psg_state_e;

    // Room for NCH full-scale voices so the running sum can never wrap.
    function automatic int unsigned acc_width(input int unsigned iw, input int unsigned nch);
        return iw + $clog2(nch);
    endfunction

endpackage

// File: rtl/psg_saturate.sv
// Shift-and-clamp of a wide accumulator down to an OW-bit unsigned sample,
// flagging when the clamp engaged.
module psg_saturate #(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 30,
    parameter int unsigned OW = 16
) (
    input  logic [AW-1:0] acc_i,
    output logic [OW-1:0] val_o,
    output logic          clip_o
);

    localparam int unsigned Shift = IW - OW;

    logic [AW-1:0] shifted;

    assign shifted = acc_i >> Shift;

    always_comb begin
        clip_o = |shifted[AW-1:OW];
        val_o  = clip_o ? {OW{1'b1}} : shifted[OW-1:0];
    end

endmodule

// File: rtl/psg_output_mixer.sv
// Snapshots NCH voice samples on a strobe, sums enabled voices serially,
// then saturates and presents the result on a valid/ready stream.
module psg_output_mixer
    import psg_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned IW  = 30,
    parameter int unsigned OW  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              strobe_i,
    input  logic [NCH*IW-1:0] ch_i,
    input  logic [NCH-1:0]    ch_en_i,
    output logic [OW-1:0]     o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              clip_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned AW = acc_width(IW, NCH);
    localparam int unsigned XW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [XW-1:0] IdxLast = XW'(NCH - 1);

    psg_state_e               state_q, state_d;
    logic [AW-1:0]            acc_q, acc_d;
    logic [XW-1:0]            idx_q, idx_d;
    logic [NCH-1:0][IW-1:0]   snap_q, snap_d;
    logic [NCH-1:0]           en_q, en_d;
    logic [OW-1:0]            data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;

    logic [AW-1:0]            addend;
    logic [OW-1:0]            sat_val;
    logic                     sat_clip;

    assign addend = en_q[idx_q] ? AW'(snap_q[idx_q]) : '0;

    psg_saturate #(
        .AW (AW),
        .IW (IW),
        .OW (OW)
    ) u_saturate (
        .acc_i  (acc_q),
        .val_o  (sat_val),
        .clip_o (sat_clip)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        en_d      = en_q;
        data_d    = data_q;
        valid_d   = valid_q;
        clip_d    = 1'b0;
        // Any strobe outside IDLE is dropped, including on the handshake edge.
        overrun_d = strobe_i && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (strobe_i) begin
                    snap_d  = ch_i;
                    en_d    = ch_en_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + addend;
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxLast) begin
                    state_d = StSat;
                end
            end
            StSat: begin
                data_d  = sat_val;
                clip_d  = sat_clip;
                valid_d = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                if (o_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            en_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            en_q      <= en_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign clip_o    = clip_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_psg_output_mixer.sv
// Directed bench for psg_output_mixer with a scoreboard of expected samples.
module tb_psg_output_mixer;

    localparam int unsigned NCH = 4;
    localparam int unsigned IW  = 30;
    localparam int unsigned OW  = 16;
    localparam longint      OMAX = (64'd1 << OW) - 1;
    localparam logic [IW-1:0] VMAX = {IW{1'b1}};

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              strobe_i;
    logic [NCH*IW-1:0] ch_i;
    logic [NCH-1:0]    ch_en_i;
    logic [OW-1:0]     o_data;
    logic              o_valid;
    logic              o_ready;
    logic              clip_o;
    logic              overrun_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;

    logic [OW:0] exp_q[$];

    psg_output_mixer #(
        .NCH (NCH),
        .IW  (IW),
        .OW  (OW)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .strobe_i  (strobe_i),
        .ch_i      (ch_i),
        .ch_en_i   (ch_en_i),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .clip_o    (clip_o),
        .overrun_o (overrun_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum enabled voices, drop IW-OW LSBs, clamp to OW bits.
    function automatic logic [OW:0] model(input logic [NCH*IW-1:0] ch,
                                          input logic [NCH-1:0] en);
        longint s = 0;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) s += longint'(ch[i*IW +: IW]);
        end
        s = s >> (IW - OW);
        if (s > OMAX) return {1'b1, {OW{1'b1}}};
        return {1'b0, s[OW-1:0]};
    endfunction

    function automatic logic [NCH*IW-1:0] pack4(input longint v0, input longint v1,
                                                 input longint v2, input longint v3);
        logic [NCH*IW-1:0] r;
        r[0*IW +: IW] = v0[IW-1:0];
        r[1*IW +: IW] = v1[IW-1:0];
        r[2*IW +: IW] = v2[IW-1:0];
        r[3*IW +: IW] = v3[IW-1:0];
        return r;
    endfunction

    task automatic compare_out(input string tag);
        logic [OW:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, 64'(o_data), 64'(e[OW-1:0]));
            check({tag, "_clip"}, 64'(clip_o), 64'(e[OW]));
        end
    endtask

    // Strobe once, optionally zero the inputs right after, wait for the sample.
    task automatic strobe_and_wait(input string tag, input logic [NCH*IW-1:0] ch,
                                   input logic [NCH-1:0] en, input bit zap);
        int m;
        @(negedge clk_i);
        ch_i     = ch;
        ch_en_i  = en;
        strobe_i = 1'b1;
        exp_q.push_back(model(ch, en));
        @(negedge clk_i);
        strobe_i = 1'b0;
        if (zap) begin
            ch_i    = '0;
            ch_en_i = '0;
        end
        check({tag, "_busy_start"}, 64'(busy_o), 64'd1);
        m = 0;
        while (o_valid !== 1'b1 && m < 50) begin
            @(negedge clk_i);
            m++;
        end
        check({tag, "_latency"}, 64'(m), 64'd5);
        compare_out(tag);
    endtask

    task automatic run_sample(input string tag, input logic [NCH*IW-1:0] ch,
                              input logic [NCH-1:0] en, input bit zap);
        strobe_and_wait(tag, ch, en, zap);
        @(negedge clk_i);
        check({tag, "_valid_drop"}, 64'(o_valid), 64'd0);
        check({tag, "_clip_pulse"}, 64'(clip_o), 64'd0);
        check({tag, "_busy_end"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [OW-1:0] held;
        bit            stable;
        int            ovr;
        int            vcount;

        rst_ni   = 1'b0;
        strobe_i = 1'b0;
        ch_i     = '0;
        ch_en_i  = '0;
        o_ready  = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_clip", 64'(clip_o), 64'd0);
        check("rst_overrun", 64'(overrun_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_sample("basic", pack4(1638400, 1638400, 1638400, 1638400), 4'b1111, 1'b0);
        run_sample("sat", pack4(VMAX, VMAX, VMAX, VMAX), 4'b1111, 1'b0);
        run_sample("mask", pack4(163840, VMAX, 81920, VMAX), 4'b0101, 1'b0);
        run_sample("none", pack4(VMAX, VMAX, VMAX, VMAX), 4'b0000, 1'b0);
        run_sample("snap", pack4(1000 << 14, 2000 << 14, 3000 << 14, 4000 << 14),
                   4'b1111, 1'b1);

        // Backpressure with a dropped strobe while the sample is held.
        o_ready = 1'b0;
        strobe_and_wait("bp", pack4(7 << 14, 11 << 14, 13 << 14, 17 << 14), 4'b1111, 1'b0);
        held   = o_data;
        stable = 1'b1;
        ovr    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            strobe_i = (i == 3);
            if (o_valid !== 1'b1 || o_data !== held) stable = 1'b0;
            if (overrun_o === 1'b1) ovr++;
        end
        strobe_i = 1'b0;
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_overrun_count", 64'(ovr), 64'd1);
        o_ready = 1'b1;
        @(negedge clk_i);
        check("bp_one_transfer", 64'(o_valid), 64'd0);
        run_sample("bp_after", pack4(1 << 14, 2 << 14, 3 << 14, 4 << 14), 4'b1111, 1'b0);

        // Reset asserted during accumulation discards the sample.
        @(negedge clk_i);
        ch_i     = pack4(VMAX, VMAX, VMAX, VMAX);
        ch_en_i  = 4'b1111;
        strobe_i = 1'b1;
        @(negedge clk_i);
        strobe_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("rstmid_valid", 64'(o_valid), 64'd0);
        check("rstmid_busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (o_valid === 1'b1) vcount++;
        end
        check("rstmid_no_output", 64'(vcount), 64'd0);
        run_sample("post_rst", pack4(50 << 14, 50 << 14, 50 << 14, 50 << 14), 4'b1111, 1'b0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
